// File: rtl/apuf_classic.sv
// apuf_classic: arbiter PUF with N_STAGES cross-switchable stages and launch/race/capture/recover sequencing.
// Define APUF_SIM_DELAY_EN to give each stage deterministic transport delays for reproducible simulation.
`timescale 1ns/1ps
module apuf_classic #(
  parameter int N_STAGES      = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                tigSignal,
  input  logic                vcc,
  input  logic [N_STAGES-1:0] c,
  output logic                respReady,
  output logic                respBit,
  output logic                pathT,
  output logic                pathB,
  output logic                tigReg
);

  // state   | meaning
  // IDLE    | waiting for a trigger rise with vcc high
  // LAUNCH  | challenge latched, drive rising edge into both chains
  // RACE    | let the race settle for SETTLE_CYCLES cycles
  // CAPTURE | publish arbiter result, pulse respReady, drop launch
  // RECOVER | let both chains return to 0 before the next trigger
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] RACE    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic                tig_d;
  logic                rise;
  logic [N_STAGES-1:0] c_reg;
  logic                arb_d;
  (* keep = "true", dont_touch = "true" *) logic arb_q;

  assign rise = tigSignal & ~tig_d;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    logic t_in;
    logic b_in;
    (* keep = "true", dont_touch = "true" *) logic t_out;
    (* keep = "true", dont_touch = "true" *) logic b_out;
    if (i == 0) begin : g_head
      assign t_in = tigReg;
      assign b_in = tigReg;
    end else begin : g_link
      assign t_in = g_stage[i-1].t_out;
      assign b_in = g_stage[i-1].b_out;
    end
`ifdef APUF_SIM_DELAY_EN
    // top output always costs 10 ps, bottom output 11 ps, whichever input feeds it
    assign #0.010 t_out = c_reg[i] ? b_in : t_in;
    assign #0.011 b_out = c_reg[i] ? t_in : b_in;
`else
    assign t_out = c_reg[i] ? b_in : t_in;
    assign b_out = c_reg[i] ? t_in : b_in;
`endif
  end

  assign pathT = g_stage[N_STAGES-1].t_out;
  assign pathB = g_stage[N_STAGES-1].b_out;

`ifdef APUF_SIM_DELAY_EN
  // one tick of setup on D so that a simultaneous arrival resolves to 0
  assign #0.001 arb_d = pathT;
`else
  assign arb_d = pathT;
`endif

  always_ff @(posedge pathB or negedge tigReg) begin
    if (!tigReg) arb_q <= 1'b0;
    else         arb_q <= arb_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      cnt       <= '0;
      tig_d     <= 1'b0;
      c_reg     <= '0;
      tigReg    <= 1'b0;
      respBit   <= 1'b0;
      respReady <= 1'b0;
    end else begin
      tig_d     <= tigSignal;
      respReady <= 1'b0;
      if (!vcc) begin
        state  <= IDLE;
        tigReg <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              c_reg <= c;
              state <= LAUNCH;
            end
          end
          LAUNCH: begin
            tigReg <= 1'b1;
            cnt    <= CNT_LOAD;
            state  <= RACE;
          end
          RACE: begin
            if (cnt == '0) begin
              respBit   <= arb_q;
              respReady <= 1'b1;
              state     <= CAPTURE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CAPTURE: begin
            tigReg <= 1'b0;
            cnt    <= CNT_LOAD;
            state  <= RECOVER;
          end
          RECOVER: begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          default: begin
            tigReg <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apuf_classic.sv
// Scoreboard bench for apuf_classic: directed challenges with hand-computed race outcomes.
`timescale 1ns/1ps
module tb_apuf_classic;

  logic        clk = 1'b0;
  logic        rstN;
  logic        tigSignal;
  logic        vcc;
  logic [63:0] c;
  logic        respReady;
  logic        respBit;
  logic        pathT;
  logic        pathB;
  logic        tigReg;

  typedef struct {
    bit bitv;
    bit chk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   resp_known;

  apuf_classic dut (
    .clk       (clk),
    .rstN      (rstN),
    .tigSignal (tigSignal),
    .vcc       (vcc),
    .c         (c),
    .respReady (respReady),
    .respBit   (respBit),
    .pathT     (pathT),
    .pathB     (pathB),
    .tigReg    (tigReg)
  );

  always #100 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every respReady pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (respReady === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("resp_bit", 64'(respBit), 64'(e.bitv));
      end
    end
  end

  task automatic measure(input logic [63:0] cv, input bit eb);
    int m;
    m = cyc;
    c = cv;
    tigSignal = 1'b1;
    sb.push_back('{eb, resp_known, m + 6});
    @(negedge clk);
    check("tigReg_E0", 64'(tigReg), 64'd0);
    @(negedge clk);
    check("tigReg_E1", 64'(tigReg), 64'd1);
    check("paths_E1", 64'({pathT, pathB}), 64'd3);
    tigSignal = 1'b0;
    repeat (5) @(negedge clk);
    check("tigReg_E6", 64'(tigReg), 64'd0);
    check("paths_E6", 64'({pathT, pathB}), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
`ifdef APUF_SIM_DELAY_EN
    resp_known = 1'b1;
`else
    resp_known = 1'b0;
`endif
    rstN = 1'b0; vcc = 1'b0; tigSignal = 1'b0; c = '0;

    // reset and idle with vcc low
    repeat (3) @(negedge clk);
    check("rst_tigReg", 64'(tigReg), 64'd0);
    check("rst_ready", 64'(respReady), 64'd0);
    check("rst_respBit", 64'(respBit), 64'd0);
    check("rst_paths", 64'({pathT, pathB}), 64'd0);
    rstN = 1'b1;
    @(negedge clk); tigSignal = 1'b1;
    @(negedge clk); tigSignal = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("vcc0_tigReg", 64'(tigReg), 64'd0);
    end
    check("vcc0_respBit", 64'(respBit), 64'd0);
    check("vcc0_paths", 64'({pathT, pathB}), 64'd0);
    vcc = 1'b1;
    @(negedge clk);

    // straight chain: top 640 ps, bottom 704 ps
    measure(64'h0, 1'b1);
    // stage 0 crossed: inputs equal, same as straight
    measure(64'h1, 1'b1);
    // last stage crossed: top 703 ps, bottom 641 ps
    measure(64'h8000_0000_0000_0000, 1'b0);
    // all crossed: tie at 672 ps
    measure(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // held trigger: one measurement only
    begin
      int m;
      m = cyc; c = '0; tigSignal = 1'b1;
      sb.push_back('{1'b1, resp_known, m + 6});
      repeat (30) @(negedge clk);
      tigSignal = 1'b0;
      repeat (3) @(negedge clk);
    end

    // second rises during RACE and RECOVER are ignored
    begin
      int m;
      m = cyc; c = 64'hFFFF_FFFF_FFFF_FFFF; tigSignal = 1'b1;
      sb.push_back('{1'b0, resp_known, m + 6});
      repeat (2) @(negedge clk); tigSignal = 1'b0;
      @(negedge clk); tigSignal = 1'b1;
      @(negedge clk); tigSignal = 1'b0;
      repeat (4) @(negedge clk); tigSignal = 1'b1;
      @(negedge clk); tigSignal = 1'b0;
      repeat (6) @(negedge clk);
    end

    // set respBit to 1 before the abort so "unchanged" is observable
    measure(64'h0, 1'b1);

    // vcc drop during RACE
    begin
      int m;
      m = cyc; c = 64'hFFFF_FFFF_FFFF_FFFF; tigSignal = 1'b1;
      repeat (2) @(negedge clk); tigSignal = 1'b0;
      check("abort_tigReg_race", 64'(tigReg), 64'd1);
      @(negedge clk); vcc = 1'b0;
      @(negedge clk);
      check("abort_tigReg", 64'(tigReg), 64'd0);
      check("abort_ready", 64'(respReady), 64'd0);
      if (resp_known) check("abort_respBit", 64'(respBit), 64'd1);
      repeat (4) @(negedge clk);
      check("abort_tigReg_late", 64'(tigReg), 64'd0);
      vcc = 1'b1;
      repeat (2) @(negedge clk);
    end
    measure(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // challenge change after detect uses latched value
    begin
      int m;
      m = cyc; c = '0; tigSignal = 1'b1;
      sb.push_back('{1'b1, resp_known, m + 6});
      repeat (2) @(negedge clk); tigSignal = 1'b0;
      @(negedge clk); c = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (8) @(negedge clk);
      c = '0;
    end

    // asynchronous reset during RACE
    begin
      int m;
      m = cyc; c = '0; tigSignal = 1'b1;
      repeat (2) @(negedge clk); tigSignal = 1'b0;
      @(negedge clk);
      check("rst_race_tigReg_pre", 64'(tigReg), 64'd1);
      #20 rstN = 1'b0;
      #1;
      check("rst_race_tigReg", 64'(tigReg), 64'd0);
      check("rst_race_ready", 64'(respReady), 64'd0);
      check("rst_race_respBit", 64'(respBit), 64'd0);
      #5;
      check("rst_race_paths", 64'({pathT, pathB}), 64'd0);
      @(negedge clk); rstN = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_race_idle", 64'(tigReg), 64'd0);
    end
    measure(64'h1, 1'b1);

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
